uart_cmd_ctrl: RTL and testbench

Command sequencer behind the RS-232 receiver. It consumes deserialized bytes (`rx_enable`/`rxdata`) and parses fixed-format read/write frames. It drives a simple register bus and returns one response byte per frame to the transmitter over a valid/ready handshake. It is the single master that turns host serial traffic into register accesses.

---
 rtl/uart_cmd_pkg.sv | 19 +
 rtl/uart_cmd_ctrl_if.sv | 24 ++
 rtl/uart_cmd_timer.sv | 33 +++
 rtl/uart_cmd_ctrl.sv | 157 +++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// uart_cmd_pkg: shared constants and state type for the UART command sequencer.
package uart_cmd_pkg;

   localparam logic [7:0] OP_WRITE = 8'h57;   // 'W'
   localparam logic [7:0] OP_READ  = 8'h52;   // 'R'
   localparam logic [7:0] RSP_OK   = 8'h4B;   // 'K'
   localparam logic [7:0] RSP_BAD  = 8'h3F;   // '?'

   localparam int unsigned TICK_W = 11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ADDR,
      ST_DATA,
      ST_BUS,
      ST_RESP
   } state_t;

endpackage

// File: rtl/uart_cmd_ctrl_if.sv
// uart_cmd_ctrl_if: register bus plus response-byte handshake toward the transmitter.
interface uart_cmd_ctrl_if;

   logic [7:0] reg_addr;
   logic [7:0] reg_wdata;
   logic       reg_we;
   logic       reg_re;
   logic [7:0] reg_rdata;
   logic       reg_ack;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic       tx_ready;

   modport master (
      output reg_addr, reg_wdata, reg_we, reg_re, tx_data, tx_valid,
      input  reg_rdata, reg_ack, tx_ready
   );

   modport slave (
      input  reg_addr, reg_wdata, reg_we, reg_re, tx_data, tx_valid,
      output reg_rdata, reg_ack, tx_ready
   );

endinterface

// File: rtl/uart_cmd_timer.sv
// uart_cmd_timer: inter-byte tick counter; expire_o flags the sample that ends the wait.
// Only compiled when UART_CMD_TIMEOUT_EN is defined.
`ifdef UART_CMD_TIMEOUT_EN
module uart_cmd_timer
   import uart_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_TICKS = 1600
) (
   input  logic clk,
   input  logic reset_,
   input  logic clr_i,
   input  logic inc_i,
   output logic expire_o
);

   localparam logic [TICK_W-1:0] LAST = TICK_W'(TIMEOUT_TICKS - 1);

   logic [TICK_W-1:0] cnt_q;

   // Count sample strobes; clear has priority over increment.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_)
         cnt_q <= '0;
      else if (clr_i)
         cnt_q <= '0;
      else if (inc_i)
         cnt_q <= cnt_q + 1'b1;
   end

   assign expire_o = inc_i && (cnt_q == LAST);

endmodule
`endif

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: parses 'W' addr data / 'R' addr frames into register accesses
// and returns one response byte per frame.
// Optional inter-byte timeout enabled by defining UART_CMD_TIMEOUT_EN.
module uart_cmd_ctrl
   import uart_cmd_pkg::*;
#(
   parameter int unsigned TIMEOUT_TICKS = 1600
) (
   input  logic           clk,
   input  logic           reset_,
   input  logic           sample,
   input  logic           rx_enable,
   input  logic [7:0]     rxdata,
   uart_cmd_ctrl_if.master bus,
   output logic           busy,
   output logic           overrun,
   output logic           timeout
);

   state_t     state_q;
   logic       op_write_q;
   logic [7:0] addr_q;
   logic [7:0] wdata_q;
   logic [7:0] tx_data_q;
   logic       we_q;
   logic       re_q;
   logic       tx_valid_q;
   logic       busy_q;
   logic       overrun_q;
   logic       timeout_q;
   logic       expire;
   logic       in_wait;

   assign in_wait = (state_q == ST_ADDR) || (state_q == ST_DATA);

`ifdef UART_CMD_TIMEOUT_EN
   logic tmr_clr;
   logic tmr_inc;

   // Every accepted byte restarts the wait; outside ADDR/DATA the counter idles at zero.
   assign tmr_clr = rx_enable || !in_wait;
   assign tmr_inc = sample && in_wait;

   uart_cmd_timer #(
      .TIMEOUT_TICKS(TIMEOUT_TICKS)
   ) u_timer (
      .clk      (clk),
      .reset_   (reset_),
      .clr_i    (tmr_clr),
      .inc_i    (tmr_inc),
      .expire_o (expire)
   );
`else
   logic              unused_sample;
   logic [TICK_W-1:0] unused_ticks;
   logic              unused_in_wait;

   assign expire         = 1'b0;
   assign unused_sample  = sample;
   assign unused_ticks   = TICK_W'(TIMEOUT_TICKS);
   assign unused_in_wait = in_wait;
`endif

   // Frame sequencer; all outputs registered alongside the state.
   always_ff @(posedge clk or negedge reset_) begin
      if (!reset_) begin
         state_q    <= ST_IDLE;
         op_write_q <= 1'b0;
         addr_q     <= '0;
         wdata_q    <= '0;
         tx_data_q  <= '0;
         we_q       <= 1'b0;
         re_q       <= 1'b0;
         tx_valid_q <= 1'b0;
         busy_q     <= 1'b0;
         overrun_q  <= 1'b0;
         timeout_q  <= 1'b0;
      end else begin
         timeout_q <= 1'b0;
         unique case (state_q)
            ST_IDLE: begin
               if (rx_enable) begin
                  busy_q <= 1'b1;
                  if (rxdata == OP_WRITE || rxdata == OP_READ) begin
                     op_write_q <= (rxdata == OP_WRITE);
                     state_q    <= ST_ADDR;
                  end else begin
                     tx_data_q  <= RSP_BAD;
                     tx_valid_q <= 1'b1;
                     state_q    <= ST_RESP;
                  end
               end
            end
            ST_ADDR: begin
               if (rx_enable) begin
                  addr_q <= rxdata;
                  if (op_write_q) begin
                     state_q <= ST_DATA;
                  end else begin
                     re_q    <= 1'b1;
                     state_q <= ST_BUS;
                  end
               end else if (expire) begin
                  busy_q    <= 1'b0;
                  timeout_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end
            end
            ST_DATA: begin
               if (rx_enable) begin
                  wdata_q <= rxdata;
                  we_q    <= 1'b1;
                  state_q <= ST_BUS;
               end else if (expire) begin
                  busy_q    <= 1'b0;
                  timeout_q <= 1'b1;
                  state_q   <= ST_IDLE;
               end
            end
            ST_BUS: begin
               if (rx_enable)
                  overrun_q <= 1'b1;
               if (bus.reg_ack) begin
                  we_q       <= 1'b0;
                  re_q       <= 1'b0;
                  tx_data_q  <= op_write_q ? RSP_OK : bus.reg_rdata;
                  tx_valid_q <= 1'b1;
                  state_q    <= ST_RESP;
               end
            end
            ST_RESP: begin
               if (rx_enable)
                  overrun_q <= 1'b1;
               if (bus.tx_ready) begin
                  tx_valid_q <= 1'b0;
                  busy_q     <= 1'b0;
                  state_q    <= ST_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.reg_addr  = addr_q;
   assign bus.reg_wdata = wdata_q;
   assign bus.reg_we    = we_q;
   assign bus.reg_re    = re_q;
   assign bus.tx_data   = tx_data_q;
   assign bus.tx_valid  = tx_valid_q;
   assign busy          = busy_q;
   assign overrun       = overrun_q;
   assign timeout       = timeout_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// tb_uart_cmd_ctrl: directed frames plus random traffic against a frame-level model.
module tb_uart_cmd_ctrl;

   localparam int unsigned TICKS = 32;
`ifdef UART_CMD_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       reset_ = 1'b1;
   logic       sample = 1'b0;
   logic       rx_enable = 1'b0;
   logic [7:0] rxdata = '0;
   logic       busy;
   logic       overrun;
   logic       timeout;

   int vectors = 0;
   int miscompares = 0;

   uart_cmd_ctrl_if bus_if ();

   uart_cmd_ctrl #(
      .TIMEOUT_TICKS(TICKS)
   ) dut (
      .clk       (clk),
      .reset_    (reset_),
      .sample    (sample),
      .rx_enable (rx_enable),
      .rxdata    (rxdata),
      .bus       (bus_if),
      .busy      (busy),
      .overrun   (overrun),
      .timeout   (timeout)
   );

   always #5 clk = ~clk;

   // Frame-level model: bytes of the current frame, a pending bus access, a pending response.
   logic [7:0]  m_fb[$];
   bit          m_bus = 1'b0;
   bit          m_resp = 1'b0;
   logic [7:0]  m_tx = '0;
   logic [7:0]  m_addr = '0;
   logic [7:0]  m_wdata = '0;
   bit          m_ovr = 1'b0;
   bit          m_to = 1'b0;
   int unsigned m_ticks = 0;

   function automatic bit m_op_is(input logic [7:0] op);
      return m_bus && (m_fb.size() != 0) && (m_fb[0] == op);
   endfunction

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
      end
   endtask

   initial forever begin
      @(posedge clk or negedge reset_);
      if (!reset_) begin
         m_fb.delete();
         m_bus = 0; m_resp = 0; m_tx = '0; m_addr = '0; m_wdata = '0;
         m_ovr = 0; m_to = 0; m_ticks = 0;
      end else begin
         m_to = 0;
         if (m_resp) begin
            if (rx_enable) m_ovr = 1;
            if (bus_if.tx_ready) m_resp = 0;
         end else if (m_bus) begin
            if (rx_enable) m_ovr = 1;
            if (bus_if.reg_ack) begin
               m_tx   = (m_fb[0] == 8'h57) ? 8'h4B : bus_if.reg_rdata;
               m_bus  = 0;
               m_resp = 1;
               m_fb.delete();
            end
         end else if (rx_enable) begin
            m_fb.push_back(rxdata);
            m_ticks = 0;
            case (m_fb.size())
               1: if (m_fb[0] != 8'h57 && m_fb[0] != 8'h52) begin
                     m_tx = 8'h3F; m_resp = 1; m_fb.delete();
                  end
               2: begin
                     m_addr = m_fb[1];
                     if (m_fb[0] == 8'h52) m_bus = 1;
                  end
               default: begin
                     m_wdata = m_fb[2]; m_bus = 1;
                  end
            endcase
         end else if (TO_EN && m_fb.size() != 0 && sample) begin
            m_ticks++;
            if (m_ticks == TICKS) begin
               m_fb.delete();
               m_to = 1;
            end
         end
      end
   end

   // Compare every cycle, away from the active edge.
   initial forever begin
      @(negedge clk);
      chk("reg_we",    8'(bus_if.reg_we),   8'(m_op_is(8'h57)));
      chk("reg_re",    8'(bus_if.reg_re),   8'(m_op_is(8'h52)));
      chk("reg_addr",  bus_if.reg_addr,     m_addr);
      chk("reg_wdata", bus_if.reg_wdata,    m_wdata);
      chk("tx_valid",  8'(bus_if.tx_valid), 8'(m_resp));
      chk("tx_data",   bus_if.tx_data,      m_tx);
      chk("busy",      8'(busy),            8'(m_fb.size() != 0 || m_resp));
      chk("overrun",   8'(overrun),         8'(m_ovr));
      chk("timeout",   8'(timeout),         8'(m_to));
   end

   task automatic drive(input logic rx, input logic [7:0] d, input logic ack,
                        input logic [7:0] rd, input logic rdy, input logic smp);
      @(negedge clk);
      rx_enable        = rx;
      rxdata           = d;
      bus_if.reg_ack   = ack;
      bus_if.reg_rdata = rd;
      bus_if.tx_ready  = rdy;
      sample           = smp;
   endtask

   task automatic idle();
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   task automatic byte_in(input logic [7:0] d);
      drive(1'b1, d, 1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   initial begin
      bus_if.reg_ack   = 1'b0;
      bus_if.reg_rdata = '0;
      bus_if.tx_ready  = 1'b0;
      #1 reset_ = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_we",       8'(bus_if.reg_we),   8'h00);
      chk("rst_tx_valid", 8'(bus_if.tx_valid), 8'h00);
      chk("rst_busy",     8'(busy),            8'h00);
      chk("rst_addr",     bus_if.reg_addr,     8'h00);
      reset_ = 1'b1;

      // Write with three wait cycles before ack.
      byte_in(8'h57); byte_in(8'h10); byte_in(8'hA5);
      idle();
      chk("wr_we",    8'(bus_if.reg_we), 8'h01);
      chk("wr_addr",  bus_if.reg_addr,   8'h10);
      chk("wr_wdata", bus_if.reg_wdata,  8'hA5);
      idle(); idle();
      chk("wr_we_hold", 8'(bus_if.reg_we), 8'h01);
      drive(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
      idle();
      chk("wr_tx_valid", 8'(bus_if.tx_valid), 8'h01);
      chk("wr_tx_data",  bus_if.tx_data,      8'h4B);
      chk("wr_we_fall",  8'(bus_if.reg_we),   8'h00);
      idle();
      chk("wr_tx_hold",  8'(bus_if.tx_valid), 8'h01);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      idle();
      chk("wr_tx_done",  8'(bus_if.tx_valid), 8'h00);
      chk("wr_idle",     8'(busy),            8'h00);

      // Read acknowledged in the first bus cycle.
      byte_in(8'h52); byte_in(8'h22);
      drive(1'b0, 8'h00, 1'b1, 8'h5C, 1'b0, 1'b0);
      chk("rd_re",   8'(bus_if.reg_re), 8'h01);
      chk("rd_addr", bus_if.reg_addr,   8'h22);
      idle();
      chk("rd_re_one", 8'(bus_if.reg_re), 8'h00);
      chk("rd_data",   bus_if.tx_data,    8'h5C);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      idle();

      // Unknown opcode, then a normal read.
      byte_in(8'h41);
      idle();
      chk("bad_tx_valid", 8'(bus_if.tx_valid), 8'h01);
      chk("bad_tx_data",  bus_if.tx_data,      8'h3F);
      chk("bad_no_bus",   8'(bus_if.reg_we | bus_if.reg_re), 8'h00);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      byte_in(8'h52); byte_in(8'h01);
      drive(1'b0, 8'h00, 1'b1, 8'h99, 1'b0, 1'b0);
      idle();
      chk("bad_next_rd", bus_if.tx_data, 8'h99);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      idle();

`ifdef UART_CMD_TIMEOUT_EN
      // Silent line for TICKS samples aborts the frame.
      byte_in(8'h57); byte_in(8'h10);
      repeat (TICKS) drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
      idle();
      chk("to_pulse", 8'(timeout),         8'h01);
      chk("to_idle",  8'(busy),            8'h00);
      chk("to_no_tx", 8'(bus_if.tx_valid), 8'h00);
      idle();
      chk("to_one",   8'(timeout),         8'h00);
      // Byte on the expiring sample wins and restarts the count.
      byte_in(8'h57);
      repeat (TICKS - 1) drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
      drive(1'b1, 8'h10, 1'b0, 8'h00, 1'b0, 1'b1);
      repeat (TICKS - 1) drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b1);
      idle();
      chk("to_restart_busy", 8'(busy),    8'h01);
      chk("to_restart_none", 8'(timeout), 8'h00);
      byte_in(8'hA5);
      drive(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
      idle();
      chk("to_restart_resp", bus_if.tx_data, 8'h4B);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      idle();
`endif

      // Byte during the bus wait is dropped and flagged.
      chk("ovr_clear", 8'(overrun), 8'h00);
      byte_in(8'h57); byte_in(8'h10); byte_in(8'h3C);
      idle();
      byte_in(8'h77);
      drive(1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b0);
      idle();
      chk("ovr_set",  8'(overrun),   8'h01);
      chk("ovr_resp", bus_if.tx_data, 8'h4B);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      idle(); idle();
      chk("ovr_sticky", 8'(overrun), 8'h01);

      // Asynchronous reset while a write is pending.
      byte_in(8'h57); byte_in(8'h10); byte_in(8'hA5);
      idle();
      chk("rb_we", 8'(bus_if.reg_we), 8'h01);
      #2 reset_ = 1'b0;
      #1;
      chk("rb_we_async",  8'(bus_if.reg_we), 8'h00);
      chk("rb_addr",      bus_if.reg_addr,   8'h00);
      chk("rb_wdata",     bus_if.reg_wdata,  8'h00);
      chk("rb_overrun",   8'(overrun),       8'h00);
      @(negedge clk);
      reset_ = 1'b1;
      byte_in(8'h52); byte_in(8'h03);
      drive(1'b0, 8'h00, 1'b1, 8'h6E, 1'b0, 1'b0);
      idle();
      chk("rb_read", bus_if.tx_data, 8'h6E);
      drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0);
      idle();

      // Random traffic, stray acks, back-pressure and occasional resets.
      for (int i = 0; i < 3000; i++) begin
         logic [7:0] d;
         int unsigned pick;
         pick = $urandom_range(0, 9);
         d = (pick < 4) ? 8'h57 : (pick < 7) ? 8'h52 : 8'($urandom);
         drive(1'($urandom_range(0, 3) == 0), d, 1'($urandom_range(0, 2) == 0),
               8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) == 0));
         if (!reset_) begin
            #2 reset_ = 1'b1;
         end else if ($urandom_range(0, 599) == 0) begin
            #2 reset_ = 1'b0;
         end
      end
      idle(); idle();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
